// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - command/result handshake bundle for the shift sequencer
interface shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;

    // Command source / result consumer side
    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data, busy
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle rotate command sequencer; optional SHIFT_SEQ_CNT_MOD_EN folds count modulo WIDTH
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    shift_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_ROTL = 2'd1;
    localparam logic [1:0] OP_ROTR = 2'd2;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] c_q, c_d;
    logic             left_q, left_d;
    logic [CNT_W-1:0] n_eff;

    // Effective step count decided once, at acceptance
`ifdef SHIFT_SEQ_CNT_MOD_EN
    assign n_eff = CNT_W'(32'(bus.cmd_cnt) % WIDTH);
`else
    assign n_eff = bus.cmd_cnt;
`endif

    // Next-state, result register and remaining-count logic
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        left_d  = left_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op == OP_ROTL || bus.cmd_op == OP_ROTR) begin
                        r_d     = bus.cmd_data;
                        c_d     = n_eff;
                        left_d  = (bus.cmd_op == OP_ROTL);
                        state_d = (n_eff != '0) ? SHIFT : DONE;
                    end else begin
                        if (bus.cmd_op == OP_LOAD) begin
                            r_d = bus.cmd_data;
                        end
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (left_q) begin
                    r_d = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                end else begin
                    r_d = {r_q[0], r_q[WIDTH-1:1]};
                end
                // Count is nonzero on entry; the guard keeps it from wrapping regardless
                if (c_q <= CNT_W'(1)) begin
                    c_d     = '0;
                    state_d = DONE;
                end else begin
                    c_d = c_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset overrides any handshake on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            left_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            left_q  <= left_d;
        end
    end

    // Handshake outputs derive directly from the state register
    always_comb begin
        bus.cmd_ready = (state_q == IDLE) && !rst;
        bus.res_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.res_data  = r_q;
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed scoreboard bench for shift_sequencer
module tb_shift_sequencer;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] data;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         passes = 0;
    logic [3:0] last_res = 4'b0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] rot(input logic [3:0] d, input bit left, input int n);
        logic [3:0] x;
        x = d;
        for (int i = 0; i < n; i++) begin
            x = left ? {x[2:0], x[3]} : {x[0], x[3:1]};
        end
        return x;
    endfunction

    function automatic int n_eff(input int n);
`ifdef SHIFT_SEQ_CNT_MOD_EN
        return n % WIDTH;
`else
        return n;
`endif
    endfunction

    task automatic issue(input string tag, input logic [1:0] op, input logic [2:0] cnt,
                         input logic [3:0] data, input logic [3:0] exp_data);
        exp_t e;
        e.data = exp_data;
        e.lat  = ((op == 2'd1 || op == 2'd2) ? n_eff(int'(cnt)) : 0) + 1;
        sb.push_back(e);
        @(negedge clk);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_cnt   = cnt;
        bus.cmd_data  = data;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ~op;
        bus.cmd_cnt   = ~cnt;
        bus.cmd_data  = ~data;
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        int   n;
        bit   busy_ok;
        n       = 1;
        busy_ok = 1'b1;
        @(negedge clk);
        while (!bus.res_valid && n < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, 32'(n), 32'(e.lat));
            check({tag, "_res_data"}, 32'(bus.res_data), 32'(e.data));
            check({tag, "_busy_shift"}, 32'(busy_ok), 32'd1);
            check({tag, "_ready_in_done"}, 32'(bus.cmd_ready), 32'd0);
            last_res = e.data;
        end
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid_low"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_cnt   = 3'd0;
        bus.cmd_data  = 4'd0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(bus.cmd_ready), 32'd1);

        issue("load", 2'd0, 3'd0, 4'b1011, 4'b1011);
        wait_result("load");
        take("load");

        issue("rotl1", 2'd1, 3'd1, 4'b1001, 4'b0011);
        wait_result("rotl1");
        take("rotl1");

        issue("rotr2", 2'd2, 3'd2, 4'b1001, 4'b0110);
        wait_result("rotr2");
        take("rotr2");

        issue("rotl5", 2'd1, 3'd5, 4'b0001, 4'b0010);
        wait_result("rotl5");
        take("rotl5");

        issue("rotl0", 2'd1, 3'd0, 4'b0101, 4'b0101);
        wait_result("rotl0");
        take("rotl0");

        issue("rotl4", 2'd1, 3'd4, 4'b1000, 4'b1000);
        wait_result("rotl4");
        take("rotl4");

        issue("rotr7", 2'd2, 3'd7, 4'b0001, rot(4'b0001, 1'b0, 7));
        wait_result("rotr7");

        // Backpressure: result held while a new command is offered
        for (int i = 0; i < 3; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 2'd0;
            bus.cmd_data  = 4'b0000;
            @(negedge clk);
            check("bp_valid", 32'(bus.res_valid), 32'd1);
            check("bp_data", 32'(bus.res_data), 32'(last_res));
            check("bp_no_accept", 32'(bus.cmd_ready), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        take("bp");

        issue("hold", 2'd3, 3'd0, 4'b1111, last_res);
        wait_result("hold");
        take("hold");

        // Reset abort during a long rotate
        issue("abort", 2'd1, 3'd6, 4'b0011, rot(4'b0011, 1'b1, 6));
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        last_res = 4'b0000;
        @(negedge clk);
        check("abort_res_valid", 32'(bus.res_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_res_data", 32'(bus.res_data), 32'd0);
        check("abort_ready_in_rst", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", 32'(bus.cmd_ready), 32'd1);

        issue("hold_after_rst", 2'd3, 3'd0, 4'b1111, last_res);
        wait_result("hold_after_rst");
        take("hold_after_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
